// File: rtl/instr_assembler.sv
`default_nettype none
// ============================================================================
// Module      : instr_assembler
// Description : Builds INSTR_W-bit instructions from consecutive BUS_W-bit
//               memory-bus beats and queues completed instructions in a
//               DEPTH-entry FIFO. The FIFO head is presented together with
//               its opcode and address fields through a valid/ready handshake.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               flush           - drop the partial word and the FIFO contents
//               data_in/vld/rdy - beat input handshake
//               instr_vld/rdy   - instruction output handshake
//               instr/opcode/addr - FIFO head and its fields (zero when empty)
//               beat_cnt, count - beats in the partial word, FIFO occupancy
//               overflow        - beat offered while the final slot is stalled
// Revision    : 1.0 - initial release
// ============================================================================
module instr_assembler #(
    parameter int BUS_W        = 8,
    parameter int INSTR_W      = 16,
    parameter int OPC_W        = 3,
    parameter int DEPTH        = 2,
    parameter int MSB_FIRST    = 1,
    parameter int ABORT_ON_GAP = 1,
    localparam int NBEAT       = INSTR_W / BUS_W,
    localparam int BC_W        = (NBEAT > 1) ? $clog2(NBEAT) : 1,
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [BUS_W-1:0]         data_in,
    input  logic                     data_vld,
    output logic                     data_rdy,
    output logic                     instr_vld,
    input  logic                     instr_rdy,
    output logic [INSTR_W-1:0]       instr,
    output logic [OPC_W-1:0]         opcode,
    output logic [INSTR_W-OPC_W-1:0] addr,
    output logic [BC_W-1:0]          beat_cnt,
    output logic [CNT_W-1:0]         count,
    output logic                     overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [BC_W-1:0]  LAST_BEAT = BC_W'(NBEAT - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);

    logic [INSTR_W-1:0] partial;
    logic [INSTR_W-1:0] word_next;
    logic [INSTR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    logic last_beat;
    logic fifo_full;
    logic pop;
    logic accept;
    logic push;
    logic gap_abort;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake decode. A pop frees a slot in the same cycle, so a full FIFO
    // only stalls the final beat when the consumer is not taking the head.
    always_comb begin
        instr_vld = (count != '0);
        pop       = instr_vld && instr_rdy;
        last_beat = (beat_cnt == LAST_BEAT);
        fifo_full = (count == FULL_CNT);
        data_rdy  = !(last_beat && fifo_full && !pop);
        accept    = data_vld && data_rdy;
        push      = accept && last_beat;
        overflow  = data_vld && !data_rdy;
        // A stalled final beat keeps data_vld high, so it never looks like a gap.
        gap_abort = (ABORT_ON_GAP != 0) && !data_vld && (beat_cnt != '0);
    end

    // Partial word with the current beat merged into slot beat_cnt; on the
    // final beat this is the completed instruction written into the FIFO.
    always_comb begin
        word_next = partial;
        for (int k = 0; k < NBEAT; k++) begin
            if (beat_cnt == BC_W'(k)) begin
                if (MSB_FIRST != 0) begin
                    word_next[INSTR_W-1-k*BUS_W -: BUS_W] = data_in;
                end else begin
                    word_next[k*BUS_W +: BUS_W] = data_in;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            beat_cnt <= '0;
            partial  <= '0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (accept) begin
                if (last_beat) begin
                    beat_cnt <= '0;
                    partial  <= '0;
                end else begin
                    beat_cnt <= beat_cnt + BC_W'(1);
                    partial  <= word_next;
                end
            end else if (gap_abort) begin
                beat_cnt <= '0;
                partial  <= '0;
            end

            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero whenever count is 0.
    // When full with a pop, wr_ptr equals rd_ptr, so the new word replaces
    // the departing head and the order is preserved.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem[wr_ptr] <= word_next;
        end
    end

    always_comb begin
        instr  = instr_vld ? mem[rd_ptr] : '0;
        opcode = instr[INSTR_W-1 -: OPC_W];
        addr   = instr[INSTR_W-OPC_W-1:0];
    end

endmodule
`default_nettype wire
